pipe_collide: RTL

PIPE_COLLIDE -- requirements
Module: pipe_collide

---
 rtl/flappy_pkg.sv | 14 +
 rtl/bcd_counter2.sv | 29 ++
 rtl/pipe_collide.sv | 127 ++++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game blocks: FSM state encoding,
// BCD score width and screen coordinate width.
package flappy_pkg;

    localparam int SCORE_W = 8;   // two packed BCD digits
    localparam int COORD_W = 12;  // unsigned screen coordinates

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit packed BCD counter that saturates at 99.
// Ports:
//   clk - clock, rst - synchronous active-high reset (to 00)
//   clr - synchronous clear to 00, en - increment by one
//   q   - counter value, {tens, ones}
module bcd_counter2
    import flappy_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    output logic [SCORE_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            if (q == 8'h99)
                q <= q;
            else if (q[3:0] == 4'd9)
                q <= {q[7:4] + 4'd1, 4'd0};
            else
                q <= {q[7:4], q[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/pipe_collide.sv
// Game state machine for a flappy-bird style game: collision of the bird
// against the current pipe, ground and ceiling, scoring on passing a pipe,
// best-score tracking and a restart hold-off after death.
// All evaluation happens on physics strobes; outputs are registered.
// Ports:
//   i_clk, i_rst (sync, active high), i_physics_stb, i_flap
//   p1_x1/p1_x2/p1_y1/p1_y2 - pipe left/right edge, hole top/bottom
//   b_x1/b_x2/b_y1/b_y2     - bird box left/right/top/bottom
//   o_state (0 IDLE, 1 PLAY, 2 DEAD), o_score / o_best (BCD),
//   o_hit (pulse on PLAY->DEAD), o_point (pulse on each score increment)
module pipe_collide
    import flappy_pkg::*;
#(
    parameter int D_HEIGHT  = 480,
    parameter int DEAD_HOLD = 60
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_physics_stb,
    input  logic               i_flap,
    input  logic [COORD_W-1:0] p1_x1,
    input  logic [COORD_W-1:0] p1_x2,
    input  logic [COORD_W-1:0] p1_y1,
    input  logic [COORD_W-1:0] p1_y2,
    input  logic [COORD_W-1:0] b_x1,
    input  logic [COORD_W-1:0] b_x2,
    input  logic [COORD_W-1:0] b_y1,
    input  logic [COORD_W-1:0] b_y2,
    output logic [1:0]         o_state,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_best,
    output logic               o_hit,
    output logic               o_point
);

    localparam int HW = (DEAD_HOLD > 0) ? $clog2(DEAD_HOLD + 1) : 1;
    localparam logic [HW-1:0]      HOLD_INIT = HW'(DEAD_HOLD);
    localparam logic [COORD_W-1:0] GROUND    = COORD_W'(D_HEIGHT);

    state_t       state, state_nxt;
    logic         passed, passed_nxt;
    logic [HW-1:0] hold, hold_nxt;
    logic [SCORE_W-1:0] best_nxt;
    logic         hit_nxt, point_nxt;
    logic         score_clr, score_en;
    logic         x_overlap, pipe_hit, edge_hit;

    // Exact contact with the hole boundary is not a hit.
    assign x_overlap = (b_x2 > p1_x1) && (b_x1 < p1_x2);
    assign pipe_hit  = x_overlap && ((b_y1 < p1_y1) || (b_y2 > p1_y2));
    assign edge_hit  = (b_y2 >= GROUND) || (b_y1 == '0);

    assign o_state = state;

    always_comb begin
        state_nxt  = state;
        passed_nxt = passed;
        hold_nxt   = hold;
        best_nxt   = o_best;
        hit_nxt    = 1'b0;
        point_nxt  = 1'b0;
        score_clr  = 1'b0;
        score_en   = 1'b0;
        if (i_physics_stb) begin
            case (state)
                IDLE: begin
                    if (i_flap) begin
                        state_nxt  = PLAY;
                        score_clr  = 1'b1;
                        passed_nxt = 1'b0;
                    end
                end
                PLAY: begin
                    // Pipe has respawned to the right: re-arm scoring.
                    if (p1_x1 > b_x2)
                        passed_nxt = 1'b0;
                    if (pipe_hit || edge_hit) begin
                        state_nxt = DEAD;
                        hit_nxt   = 1'b1;
                        hold_nxt  = HOLD_INIT;
                        // Packed BCD orders the same as binary.
                        if (o_score > o_best)
                            best_nxt = o_score;
                    end else if (!passed && (p1_x2 < b_x1)) begin
                        score_en   = 1'b1;
                        point_nxt  = 1'b1;
                        passed_nxt = 1'b1;
                    end
                end
                DEAD: begin
                    if (hold != '0)
                        hold_nxt = hold - 1'b1;
                    else if (i_flap)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            passed  <= 1'b0;
            hold    <= '0;
            o_best  <= '0;
            o_hit   <= 1'b0;
            o_point <= 1'b0;
        end else begin
            state   <= state_nxt;
            passed  <= passed_nxt;
            hold    <= hold_nxt;
            o_best  <= best_nxt;
            o_hit   <= hit_nxt;
            o_point <= point_nxt;
        end
    end

    bcd_counter2 u_score (
        .clk (i_clk),
        .rst (i_rst),
        .clr (score_clr),
        .en  (score_en),
        .q   (o_score)
    );

endmodule
